cache_axi_bridge: RTL



---
 rtl/cache_axi_bridge_pkg.sv | 34 +++
 rtl/cache_axi_bridge_if.sv | 63 ++++++
 rtl/cache_axi_bridge_wr_ctrl.sv | 106 ++++++++++
 rtl/cache_axi_bridge.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cache_axi_bridge_pkg.sv
// Shared constants, state encodings and helpers for the cache/AXI bridge.
// Imported by the bridge top, its write controller and the bus interface.
package cache_axi_bridge_pkg;

    localparam logic [2:0] TYPE_LINE = 3'b100;
    localparam logic [2:0] TYPE_WORD = 3'b010;

    localparam int LINE_WORDS_DFLT = 4;

    localparam logic [2:0] AXI_SIZE_4B = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_WR_ID = 4'd1;

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_R
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_B
    } wr_state_e;

    // AXI len field: full line burst or a single beat.
    function automatic logic [7:0] burst_len(
        input logic [2:0] req_type,
        input int words
    );
        return (req_type == TYPE_LINE) ? 8'(words - 1) : 8'd0;
    endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// AXI4 master-side bus bundle for the cache bridge.
// master: the bridge; slave: the memory/interconnect side.
interface cache_axi_bridge_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready
    );

endinterface

// File: rtl/cache_axi_bridge_wr_ctrl.sv
// Write path: latches a line write-back or uncached store and drives AW/W/B.
// Exposes busy and the latched line address for read-after-write blocking.
module cache_axi_bridge_wr_ctrl
    import cache_axi_bridge_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DFLT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic         busy,
    output logic [27:0]  line_addr,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic         bvalid,
    output logic         bready
);

    wr_state_e      state, state_n;
    logic [31:0]    addr_q;
    logic [7:0]     len_q;
    logic [3:0]     strb_q;
    logic [127:0]   data_q;
    logic [1:0]     cnt;
    logic           aw_done;
    logic           w_done;
    logic           accept;
    logic           aw_hs;
    logic           w_hs;

    assign wr_rdy    = !reset && (state == W_IDLE);
    assign accept    = wr_req && wr_rdy;
    assign busy      = (state != W_IDLE);
    assign line_addr = addr_q[31:4];

    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awvalid = (state == W_DATA) && !aw_done;
    assign wvalid  = (state == W_DATA) && !w_done;
    assign wdata   = data_q[{cnt, 5'd0} +: 32];
    assign wstrb   = strb_q;
    assign wlast   = wvalid && ({6'd0, cnt} == len_q);
    assign bready  = (state == W_B);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= W_IDLE;
        else       state <= state_n;
    end

    // Next state: leave W_DATA once both AW and the final W beat are done.
    always_comb begin
        state_n = state;
        unique case (state)
            W_IDLE: if (accept) state_n = W_DATA;
            W_DATA: if ((aw_done || aw_hs) &&
                        (w_done || (w_hs && wlast)))
                        state_n = W_B;
            W_B:    if (bvalid) state_n = W_IDLE;
            default: state_n = W_IDLE;
        endcase
    end

    // Request latch, beat counter and per-channel completion flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            len_q   <= '0;
            strb_q  <= '0;
            data_q  <= '0;
            cnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (accept) begin
            addr_q  <= wr_addr;
            len_q   <= burst_len(wr_type, LINE_WORDS);
            strb_q  <= (wr_type == TYPE_LINE) ? 4'hf : wr_wstrb;
            data_q  <= wr_data;
            cnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == W_DATA) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) begin
                if (wlast) w_done <= 1'b1;
                else       cnt    <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/cache_axi_bridge.sv
// Bridges ICache/DCache miss and write-back requests onto one AXI4 master.
// Read FSM lives here; the write path is cache_axi_bridge_wr_ctrl.
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DFLT,
    parameter int ID_INST    = 0,
    parameter int ID_DATA    = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inst_rd_req,
    input  logic [2:0]   inst_rd_type,
    input  logic [31:0]  inst_rd_addr,
    output logic         inst_rd_rdy,
    output logic         inst_ret_valid,
    output logic         inst_ret_last,
    input  logic         data_rd_req,
    input  logic [2:0]   data_rd_type,
    input  logic [31:0]  data_rd_addr,
    output logic         data_rd_rdy,
    output logic         data_ret_valid,
    output logic         data_ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    cache_axi_bridge_if.master axi
);

    rd_state_e   r_state, r_state_n;
    logic [3:0]  ar_id_q;
    logic [31:0] ar_addr_q;
    logic [7:0]  ar_len_q;
    logic        wr_busy;
    logic [27:0] wr_line;
    logic        raw_block;
    logic        data_acc;
    logic        inst_acc;
    logic        beat;
    logic        unused_rresp;

    assign raw_block   = wr_busy && (data_rd_addr[31:4] == wr_line);
    assign data_rd_rdy = !reset && (r_state == R_IDLE) && !raw_block;
    assign inst_rd_rdy = !reset && (r_state == R_IDLE) && !data_rd_req;
    assign data_acc    = data_rd_req && data_rd_rdy;
    assign inst_acc    = inst_rd_req && inst_rd_rdy;

    assign axi.arid    = ar_id_q;
    assign axi.araddr  = ar_addr_q;
    assign axi.arlen   = ar_len_q;
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = (r_state == R_AR);
    assign axi.rready  = (r_state == R_R);

    assign beat           = axi.rready && axi.rvalid;
    assign inst_ret_valid = beat && (axi.rid == 4'(ID_INST));
    assign data_ret_valid = beat && (axi.rid == 4'(ID_DATA));
    assign inst_ret_last  = inst_ret_valid && axi.rlast;
    assign data_ret_last  = data_ret_valid && axi.rlast;
    assign ret_data       = axi.rdata;
    assign unused_rresp   = ^axi.rresp;

    assign axi.awid    = AXI_WR_ID;
    assign axi.awsize  = AXI_SIZE_4B;
    assign axi.awburst = AXI_BURST_INCR;

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_state_n;
    end

    // Read next state: accept, AR handshake, then beats until rlast.
    always_comb begin
        r_state_n = r_state;
        unique case (r_state)
            R_IDLE: if (data_acc || inst_acc) r_state_n = R_AR;
            R_AR:   if (axi.arready) r_state_n = R_R;
            R_R:    if (axi.rvalid && axi.rlast) r_state_n = R_IDLE;
            default: r_state_n = R_IDLE;
        endcase
    end

    // Latch the granted read; data has priority over inst.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
        end else if (data_acc) begin
            ar_id_q   <= 4'(ID_DATA);
            ar_addr_q <= data_rd_addr;
            ar_len_q  <= burst_len(data_rd_type, LINE_WORDS);
        end else if (inst_acc) begin
            ar_id_q   <= 4'(ID_INST);
            ar_addr_q <= inst_rd_addr;
            ar_len_q  <= burst_len(inst_rd_type, LINE_WORDS);
        end
    end

    cache_axi_bridge_wr_ctrl #(
        .LINE_WORDS (LINE_WORDS)
    ) u_wr_ctrl (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .busy      (wr_busy),
        .line_addr (wr_line),
        .awaddr    (axi.awaddr),
        .awlen     (axi.awlen),
        .awvalid   (axi.awvalid),
        .awready   (axi.awready),
        .wdata     (axi.wdata),
        .wstrb     (axi.wstrb),
        .wlast     (axi.wlast),
        .wvalid    (axi.wvalid),
        .wready    (axi.wready),
        .bvalid    (axi.bvalid),
        .bready    (axi.bready)
    );

endmodule
